// File: rtl/kmeans_ctrl_pkg.sv
// Package: kmeans_ctrl_pkg
// Shared definitions for the k-means iteration sequencer: FSM state encoding,
// problem geometry (4 centroids, 2 dimensions), centroid-index and iteration
// counter widths.
package kmeans_ctrl_pkg;

    localparam int K      = 4;
    localparam int DIM    = 2;
    localparam int CIDX_W = 2;
    localparam int ITER_W = 8;

    typedef logic [ITER_W-1:0] iter_t;
    typedef logic [CIDX_W-1:0] cidx_t;

    localparam cidx_t LAST_CIDX = cidx_t'(K - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        FEED   = 3'd2,
        DRAIN  = 3'd3,
        READ   = 3'd4,
        DIV    = 3'd5,
        UPDATE = 3'd6,
        DONE   = 3'd7
    } state_t;

endpackage

// File: rtl/kmeans_k4n2_control_if.sv
// Interface: kmeans_k4n2_control_if
// Link between the iteration sequencer (master) and the accumulator block (slave).
//   acc_rst            master->slave  clear all accumulator lines
//   acc_enable         master->slave  accumulate the current pipeline output
//   rd_acc_en          master->slave  sequencer owns the accumulator read port
//   rd_acc_centroid    master->slave  accumulator line being read
//   acc0_output        slave->master  d0 sum of rd_acc_centroid (combinational)
//   acc1_output        slave->master  d1 sum of rd_acc_centroid (combinational)
//   acc_counter_output slave->master  point count of rd_acc_centroid (combinational)
// Handshake: acc_enable acts as a valid with an implicit, always-high ready --
// the accumulator must take a sample on every cycle acc_enable is high, so there
// is no back-pressure. Reads need no handshake: the read data is a combinational
// function of rd_acc_centroid and is sampled in the same cycle.
interface kmeans_k4n2_control_if
    import kmeans_ctrl_pkg::*;
#(
    parameter int acc_width = 16,
    parameter int cnt_width = 8
);
    logic                 acc_rst;
    logic                 acc_enable;
    logic                 rd_acc_en;
    cidx_t                rd_acc_centroid;
    logic [acc_width-1:0] acc0_output;
    logic [acc_width-1:0] acc1_output;
    logic [cnt_width-1:0] acc_counter_output;

    modport master (
        output acc_rst, acc_enable, rd_acc_en, rd_acc_centroid,
        input  acc0_output, acc1_output, acc_counter_output
    );

    modport slave (
        input  acc_rst, acc_enable, rd_acc_en, rd_acc_centroid,
        output acc0_output, acc1_output, acc_counter_output
    );
endinterface

// File: rtl/kmeans_seq_div.sv
// Module: kmeans_seq_div
// Unsigned restoring divider, one quotient bit per cycle.
// Ports:
//   clk, rst (sync, active-low)
//   start     in   accepted only while not busy; operands sampled that cycle
//   dividend  in   dividend_width
//   divisor   in   divisor_width
//   busy      out  division in progress (includes the done cycle)
//   done      out  one-cycle pulse, quotient valid
//   quotient  out  low quotient_width bits of the quotient
// Latency: start cycle to done cycle inclusive is dividend_width+1 cycles.
// A zero divisor yields an all-ones quotient (every trial subtract succeeds).
module kmeans_seq_div #(
    parameter int dividend_width = 16,
    parameter int divisor_width  = 8,
    parameter int quotient_width = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [dividend_width-1:0] dividend,
    input  logic [divisor_width-1:0]  divisor,
    output logic                      busy,
    output logic                      done,
    output logic [quotient_width-1:0] quotient
);
    localparam int NW = dividend_width;
    localparam int DW = divisor_width;
    localparam int CW = $clog2(NW + 1);
    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t LAST_STEP = cnt_t'(NW);

    logic          busy_q;
    cnt_t          step_q;
    logic [DW-1:0] rem_q, dv_q;
    logic [NW-1:0] quo_q;

    logic [DW-1:0] rem_in, dv_in, rem_nx;
    logic [NW-1:0] quo_in, quo_nx;
    logic [DW:0]   rem_sh;
    logic          ge;

    // The first step is taken on the start edge directly from the operands,
    // which is what brings the latency down to NW+1 cycles.
    always_comb begin
        rem_in = busy_q ? rem_q : '0;
        quo_in = busy_q ? quo_q : dividend;
        dv_in  = busy_q ? dv_q  : divisor;
        rem_sh = {rem_in, quo_in[NW-1]};
        ge     = (rem_sh >= {1'b0, dv_in});
        // On success the true difference is below the divisor, so DW-bit
        // modular arithmetic gives the exact remainder.
        rem_nx = ge ? (rem_sh[DW-1:0] - dv_in) : rem_sh[DW-1:0];
        quo_nx = {quo_in[NW-2:0], ge};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q <= 1'b0;
            step_q <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dv_q   <= '0;
        end else if (!busy_q) begin
            if (start) begin
                busy_q <= 1'b1;
                step_q <= cnt_t'(1);
                rem_q  <= rem_nx;
                quo_q  <= quo_nx;
                dv_q   <= dv_in;
            end
        end else if (step_q == LAST_STEP) begin
            busy_q <= 1'b0;
        end else begin
            step_q <= step_q + 1'b1;
            rem_q  <= rem_nx;
            quo_q  <= quo_nx;
        end
    end

    assign busy     = busy_q;
    assign done     = busy_q && (step_q == LAST_STEP);
    assign quotient = quo_q[quotient_width-1:0];

endmodule

// File: rtl/kmeans_k4n2_control.sv
// Module: kmeans_k4n2_control
// Iteration sequencer for the 4-centroid, 2-dimension k-means datapath.
// Each iteration clears the accumulators, streams every input address through
// the distance pipeline, waits for the pipeline to drain, then divides each
// accumulator sum by its point count and loads all centroids at once.
// Ports:
//   clk, rst (sync, active-low), start (pulse, honoured in IDLE/DONE only)
//   input_ram_rd_address  out  input RAM read address
//   acc                   kmeans_k4n2_control_if.master accumulator link
//   k0d0..k3d1            out  current centroids
//   busy / done           out  running / finished
//   iter_count            out  completed iterations
//   fsm_state             out  current FSM state (debug)
// Build option: define KMEANS_CONV_CHECK_EN to stop early once an UPDATE
// leaves every centroid unchanged.
module kmeans_k4n2_control
    import kmeans_ctrl_pkg::*;
#(
    parameter int input_data_width         = 8,
    parameter int input_data_qty           = 256,
    parameter int input_data_qty_bit_width = 8,
    parameter int acc_width                = 16,
    parameter int pipe_lat                 = 5,
    parameter int max_iter                 = 8,
    parameter logic [input_data_width-1:0] k0_d0_initial = 0,
    parameter logic [input_data_width-1:0] k0_d1_initial = 0,
    parameter logic [input_data_width-1:0] k1_d0_initial = 1,
    parameter logic [input_data_width-1:0] k1_d1_initial = 1,
    parameter logic [input_data_width-1:0] k2_d0_initial = 2,
    parameter logic [input_data_width-1:0] k2_d1_initial = 2,
    parameter logic [input_data_width-1:0] k3_d0_initial = 3,
    parameter logic [input_data_width-1:0] k3_d1_initial = 3
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    output logic [input_data_qty_bit_width-1:0] input_ram_rd_address,
    kmeans_k4n2_control_if.master               acc,
    output logic [input_data_width-1:0]         k0d0, k0d1, k1d0, k1d1,
    output logic [input_data_width-1:0]         k2d0, k2d1, k3d0, k3d1,
    output logic                                busy,
    output logic                                done,
    output iter_t                               iter_count,
    output state_t                              fsm_state
);
    localparam int W  = input_data_width;
    localparam int QW = input_data_qty_bit_width;
    localparam int AW = acc_width;
    typedef logic [QW-1:0]       addr_t;
    typedef logic [pipe_lat-1:0] sr_t;
    localparam addr_t LAST_ADDR  = addr_t'(input_data_qty - 1);
    // Only the final issue is left in the shift register on the last DRAIN cycle.
    localparam sr_t   SR_LAST    = sr_t'(1) << (pipe_lat - 1);
    localparam iter_t MAX_ITER_V = iter_t'(max_iter);

    state_t        state_q, state_d;
    addr_t         addr_q;
    sr_t           vld_sr_q;
    cidx_t         cidx_q;
    logic          dim_q;
    logic [AW-1:0] cap_acc0_q, cap_acc1_q;
    logic [QW-1:0] cap_cnt_q;
    logic [W-1:0]  cent_q    [K][DIM];
    logic [W-1:0]  new_q     [K][DIM];
    logic [W-1:0]  init_cent [K][DIM];
    iter_t         iter_q, iter_next;
    logic          last_iter, converged;
    logic          div_start, div_busy, div_done;
    logic [W-1:0]  div_quo;

    assign init_cent[0][0] = k0_d0_initial;
    assign init_cent[0][1] = k0_d1_initial;
    assign init_cent[1][0] = k1_d0_initial;
    assign init_cent[1][1] = k1_d1_initial;
    assign init_cent[2][0] = k2_d0_initial;
    assign init_cent[2][1] = k2_d1_initial;
    assign init_cent[3][0] = k3_d0_initial;
    assign init_cent[3][1] = k3_d1_initial;

    assign iter_next = iter_q + 1'b1;
    assign last_iter = (iter_next == MAX_ITER_V);

`ifdef KMEANS_CONV_CHECK_EN
    always_comb begin
        converged = 1'b1;
        for (int c = 0; c < K; c++)
            for (int d = 0; d < DIM; d++)
                if (new_q[c][d] != cent_q[c][d]) converged = 1'b0;
    end
`else
    assign converged = 1'b0;
`endif

    kmeans_seq_div #(
        .dividend_width (AW),
        .divisor_width  (QW),
        .quotient_width (W)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (dim_q ? cap_acc1_q : cap_acc0_q),
        .divisor  (cap_cnt_q),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quo)
    );

    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d             = state_q;
        acc.acc_rst         = (state_q == CLEAR);
        acc.acc_enable      = vld_sr_q[pipe_lat-1];
        acc.rd_acc_en       = (state_q == READ) || (state_q == DIV);
        acc.rd_acc_centroid = cidx_q;
        // The divider is not busy in the first DIV cycle of either dimension;
        // in its done cycle it still reports busy, so no double start.
        div_start           = (state_q == DIV) && !div_busy;
        case (state_q)
            IDLE, DONE: if (start) state_d = CLEAR;
            CLEAR:      state_d = FEED;
            FEED:       if (addr_q == LAST_ADDR) state_d = DRAIN;
            DRAIN:      if (vld_sr_q == SR_LAST) state_d = READ;
            READ: begin
                if (acc.acc_counter_output != '0) state_d = DIV;
                else if (cidx_q == LAST_CIDX)     state_d = UPDATE;
                else                              state_d = READ;
            end
            DIV: begin
                if (div_done && dim_q)
                    state_d = (cidx_q == LAST_CIDX) ? UPDATE : READ;
            end
            UPDATE:     state_d = (last_iter || converged) ? DONE : CLEAR;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_q     <= '0;
            vld_sr_q   <= '0;
            cidx_q     <= '0;
            dim_q      <= 1'b0;
            cap_acc0_q <= '0;
            cap_acc1_q <= '0;
            cap_cnt_q  <= '0;
            iter_q     <= '0;
            cent_q     <= init_cent;
            new_q      <= init_cent;
        end else begin
            vld_sr_q <= (vld_sr_q << 1) | sr_t'(state_q == FEED);
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        iter_q <= '0;
                        cent_q <= init_cent;
                    end
                end
                CLEAR: addr_q <= '0;
                FEED:  if (addr_q != LAST_ADDR) addr_q <= addr_q + 1'b1;
                READ: begin
                    cap_acc0_q <= acc.acc0_output;
                    cap_acc1_q <= acc.acc1_output;
                    cap_cnt_q  <= acc.acc_counter_output;
                    dim_q      <= 1'b0;
                    // Empty cluster: keep its position and skip the divider.
                    if (acc.acc_counter_output == '0) begin
                        new_q[cidx_q][0] <= cent_q[cidx_q][0];
                        new_q[cidx_q][1] <= cent_q[cidx_q][1];
                        cidx_q           <= cidx_q + 1'b1;
                    end
                end
                DIV: begin
                    if (div_done) begin
                        new_q[cidx_q][dim_q] <= div_quo;
                        dim_q                <= ~dim_q;
                        if (dim_q) cidx_q <= cidx_q + 1'b1;
                    end
                end
                UPDATE: begin
                    cent_q <= new_q;
                    iter_q <= iter_next;
                    cidx_q <= '0;
                end
                default: ;
            endcase
        end
    end

    assign input_ram_rd_address = addr_q;
    assign k0d0       = cent_q[0][0];
    assign k0d1       = cent_q[0][1];
    assign k1d0       = cent_q[1][0];
    assign k1d1       = cent_q[1][1];
    assign k2d0       = cent_q[2][0];
    assign k2d1       = cent_q[2][1];
    assign k3d0       = cent_q[3][0];
    assign k3d1       = cent_q[3][1];
    assign busy       = (state_q != IDLE) && (state_q != DONE);
    assign done       = (state_q == DONE);
    assign iter_count = iter_q;
    assign fsm_state  = state_q;

endmodule

// File: tb/tb_kmeans_k4n2_control.sv
// Testbench: tb_kmeans_k4n2_control
// Directed bench for kmeans_k4n2_control with a behavioural accumulator stub
// (fixed per-centroid sums and counts). Runs with input_data_qty=4,
// pipe_lat=5, acc_width=16, max_iter=3. Honours KMEANS_CONV_CHECK_EN.
module tb_kmeans_k4n2_control;
    import kmeans_ctrl_pkg::*;

    localparam int W = 8, QW = 8, AW = 16, QTY = 4, PL = 5, MAXIT = 3;
`ifdef KMEANS_CONV_CHECK_EN
    localparam int EXP_ITERS = 2;
`else
    localparam int EXP_ITERS = 3;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    always #5 clk = ~clk;

    logic [QW-1:0] input_ram_rd_address;
    logic [W-1:0]  k0d0, k0d1, k1d0, k1d1, k2d0, k2d1, k3d0, k3d1;
    logic          busy, done;
    iter_t         iter_count;
    state_t        fsm_state;

    kmeans_k4n2_control_if #(.acc_width(AW), .cnt_width(QW)) acc_if ();

    kmeans_k4n2_control #(
        .input_data_width         (W),
        .input_data_qty           (QTY),
        .input_data_qty_bit_width (QW),
        .acc_width                (AW),
        .pipe_lat                 (PL),
        .max_iter                 (MAXIT)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .start                (start),
        .input_ram_rd_address (input_ram_rd_address),
        .acc                  (acc_if),
        .k0d0 (k0d0), .k0d1 (k0d1), .k1d0 (k1d0), .k1d1 (k1d1),
        .k2d0 (k2d0), .k2d1 (k2d1), .k3d0 (k3d0), .k3d1 (k3d1),
        .busy                 (busy),
        .done                 (done),
        .iter_count           (iter_count),
        .fsm_state            (fsm_state)
    );

    // ---------------- accumulator stub ----------------
    // c0: 600/1 -> 88 (8-bit truncation), 10/1 -> 10
    // c1: 9/3 -> 3, 7/3 -> 2
    // c2: count 0 -> stays at (2,2)
    // c3: 21/2 -> 10, 23/2 -> 11
    logic [AW-1:0] stub_acc0 [4] = '{16'd600, 16'd9, 16'd50, 16'd21};
    logic [AW-1:0] stub_acc1 [4] = '{16'd10,  16'd7, 16'd60, 16'd23};
    logic [QW-1:0] stub_cnt  [4] = '{8'd1,    8'd3,  8'd0,   8'd2};

    always_comb begin
        acc_if.acc0_output        = stub_acc0[acc_if.rd_acc_centroid];
        acc_if.acc1_output        = stub_acc1[acc_if.rd_acc_centroid];
        acc_if.acc_counter_output = stub_cnt[acc_if.rd_acc_centroid];
    end

    // ---------------- event monitors ----------------
    int clear_cnt = 0, div_c2_cyc = 0, div_c3_cyc = 0;
    always @(posedge clk) begin
        if (acc_if.acc_rst) clear_cnt <= clear_cnt + 1;
        if (fsm_state == DIV && acc_if.rd_acc_centroid == 2'd2) div_c2_cyc <= div_c2_cyc + 1;
        if (fsm_state == DIV && acc_if.rd_acc_centroid == 2'd3) div_c3_cyc <= div_c3_cyc + 1;
    end

    // ---------------- scoreboard ----------------
    int checks = 0, failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n, pulses, base_clr, base_c2, base_c3;

        // 1: reset held two cycles with start asserted
        rst = 1'b0;
        start = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_state", fsm_state, IDLE);
        chk("rst_addr", input_ram_rd_address, 0);
        chk("rst_acc_ctl", {acc_if.acc_rst, acc_if.acc_enable, acc_if.rd_acc_en, acc_if.rd_acc_centroid}, 0);
        chk("rst_busy_done", {busy, done}, 0);
        chk("rst_iter", iter_count, 0);
        chk("rst_k3d0", k3d0, 3);
        chk("rst_k1d1", k1d1, 1);
        chk("rst_k0d0", k0d0, 0);
        start = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("idle_hold", fsm_state, IDLE);

        // 2: feed / acc_enable timing
        base_clr = clear_cnt;
        base_c2 = div_c2_cyc;
        base_c3 = div_c3_cyc;
        pulse_start();
        chk("clear_state", fsm_state, CLEAR);
        chk("clear_acc_rst", acc_if.acc_rst, 1);
        chk("clear_busy", busy, 1);
        pulses = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k <= QTY) chk($sformatf("feed_addr_%0d", k), input_ram_rd_address, k - 1);
            else if (k <= 9) chk($sformatf("hold_addr_%0d", k), input_ram_rd_address, QTY - 1);
            chk($sformatf("acc_en_%0d", k), acc_if.acc_enable, (k >= 6 && k <= 9));
            if (k == 9) chk("drain_last", fsm_state, DRAIN);
            if (k == 10) begin
                chk("read_c0_state", fsm_state, READ);
                chk("read_c0_sel", {acc_if.rd_acc_en, acc_if.rd_acc_centroid}, 3'b100);
            end
            if (acc_if.acc_enable) pulses++;
        end
        chk("acc_en_pulses", pulses, 4);

        // 3/4: division results, empty cluster, iteration latency
        n = 12;
        while (fsm_state != CLEAR && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("iter1_latency", n, 117);
        chk("iter1_count", iter_count, 1);
        chk("k0d0_trunc", k0d0, 88);
        chk("k0d1", k0d1, 10);
        chk("k1d0", k1d0, 3);
        chk("k1d1", k1d1, 2);
        chk("k2d0_empty", k2d0, 2);
        chk("k2d1_empty", k2d1, 2);
        chk("k3d0", k3d0, 10);
        chk("k3d1", k3d1, 11);
        chk("c2_no_div", div_c2_cyc - base_c2, 0);
        chk("c3_div_cycles", div_c3_cyc - base_c3, 2 * (AW + 1));

        // 5/6: iteration cap (or convergence with the option enabled)
        n = 0;
        while (!done && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("done_reached", done, 1);
        chk("final_iters", iter_count, EXP_ITERS);
        chk("clear_pulses", clear_cnt - base_clr, EXP_ITERS);
        chk("done_busy", busy, 0);
        chk("final_k3d1", k3d1, 11);

        // restart from DONE reloads initial centroids
        pulse_start();
        chk("restart_state", fsm_state, CLEAR);
        chk("restart_iter", iter_count, 0);
        chk("restart_k0d0", k0d0, 0);
        chk("restart_k3d0", k3d0, 3);

        // reach DIV in iteration 2, then check start is ignored
        n = 0;
        while (!(iter_count == 1 && fsm_state == DIV) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("reach_div_it2", (iter_count == 1 && fsm_state == DIV), 1);
        pulse_start();
        chk("start_ignored_state", fsm_state, DIV);
        chk("start_ignored_iter", iter_count, 1);
        repeat (5) @(negedge clk);

        // reset during DIV aborts immediately with initial centroids
        rst = 1'b0;
        @(negedge clk);
        chk("abort_state", fsm_state, IDLE);
        chk("abort_busy", busy, 0);
        chk("abort_rd_en", acc_if.rd_acc_en, 0);
        chk("abort_iter", iter_count, 0);
        chk("abort_k0", {k0d0, k0d1}, 16'h0000);
        chk("abort_k1", {k1d0, k1d1}, 16'h0101);
        chk("abort_k3", {k3d0, k3d1}, 16'h0303);
        rst = 1'b1;
        @(negedge clk);
        chk("post_abort_idle", fsm_state, IDLE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
